rx_edge_bit_counter_gen: RTL and testbench
==========================================

Name: rx_edge_bit_counter_gen

Overview:
Parametrised successor to the UART RX edge/bit counter. Counts oversampling edges per bit and bits per frame, and decodes three-point mid-bit sample strobes for the majority-vote sampler. Also flags bit and frame completion and catches illegal configuration. Sits between the RX FSM, which drives COUNTER_EN, and the data sampler/deserializer, which consume the strobes and counts.

Parameters:
PRESC_W, 6, width of PRESCALE and EDGE_COUNT; oversampling ratio up to 2^PRESC_W-1
BIT_W, 4, width of FRAME_BITS and BIT_COUNT
MIN_PRESCALE, 4, smallest legal prescale; must be >=4
AUTO_RESTART, 0, 1: continue into next frame after FRAME_DONE; 0: hold until COUNTER_EN drops

Ports:
CLK  in  1  clock
RST  in  1  asynchronous reset, active-high
COUNTER_EN  in  1  count enable from RX FSM
PRESCALE  in  PRESC_W  edges per bit
FRAME_BITS  in  BIT_W  bits per frame (start+data+parity+stop)
EDGE_COUNT  out  PRESC_W  edge position within current bit, 1..P; 0 when idle
BIT_COUNT  out  BIT_W  bit index within frame
SAMPLE_STRB  out  3  [0]/[1]/[2] high at edges mid-1 / mid / mid+1
BIT_DONE  out  1  last edge of current bit
FRAME_DONE  out  1  last edge of last bit of frame
CFG_ERR  out  1  sticky illegal-configuration flag

Behaviour:
- Reset (RST=1, async): EDGE_COUNT=0, BIT_COUNT=0, CFG_ERR=0, state IDLE, latched config = MIN_PRESCALE / 1. All decoded outputs are low.
- States: IDLE, RUN, HOLD.
- IDLE: counters are 0. When COUNTER_EN=1, the block latches P_L and FB_L and goes to RUN. EDGE_COUNT becomes 1 on the next edge.
- Config latch: P_L = PRESCALE, except PRESCALE<MIN_PRESCALE gives P_L=MIN_PRESCALE and sets CFG_ERR. FB_L = FRAME_BITS, except FRAME_BITS=0 gives FB_L=1 and sets CFG_ERR. PRESCALE/FRAME_BITS changes after the latch are ignored until the next IDLE->RUN.
- RUN, edge counter: if EDGE_COUNT==P_L, next value is 1; otherwise EDGE_COUNT+1.
- RUN, bit counter: increments when EDGE_COUNT==P_L. At the final bit (BIT_COUNT==FB_L-1) it wraps to 0 instead.
- BIT_DONE = state RUN && EDGE_COUNT==P_L. This is a combinational decode of registers.
- FRAME_DONE = BIT_DONE && BIT_COUNT==FB_L-1. It is a single-cycle pulse.
- Frame end with AUTO_RESTART=1: counting continues seamlessly (EDGE_COUNT=1, BIT_COUNT=0 next cycle).
- Frame end with AUTO_RESTART=0: go to HOLD. EDGE_COUNT and BIT_COUNT are 0, and no strobes are asserted.
- mid = P_L>>1 (floor). SAMPLE_STRB[i] = state RUN && EDGE_COUNT==mid-1+i. The strobes are combinational decodes. MIN_PRESCALE>=4 guarantees all three points lie within 1..P_L.
- COUNTER_EN=0 in any state: next cycle the block is in IDLE with both counters at 0, including mid-bit or mid-frame. CFG_ERR holds.
- CFG_ERR clears only on RST or on a subsequent legal latch.
- Cycle budget: first BIT_DONE comes P_L cycles after the enable cycle. FRAME_DONE asserts in cycle FB_L*P_L counted from the enable cycle as cycle 0.
- Widths: all compares are unsigned at native width, with no overflow. P_L max is 2^PRESC_W-1. FB_L max is 2^BIT_W-1.

Test Plan:
- P=8, FB=10, AUTO_RESTART=0, enable held: EDGE_COUNT runs 1..8 repeatedly; SAMPLE_STRB[0..2] at edges 3,4,5 of every bit; BIT_DONE at cycles 8,16,...,80; FRAME_DONE only at cycle 80; then HOLD with counters 0 until enable drops.
- Same stimulus, AUTO_RESTART=1: at cycle 81 EDGE_COUNT=1 and BIT_COUNT=0; second FRAME_DONE at cycle 160.
- P=5 (odd): mid=2, strobes at edges 1,2,3; PRESCALE changed to 16 mid-frame -> bit period stays 5 until re-enable.
- PRESCALE=2, FRAME_BITS=0: CFG_ERR=1, P_L=4, FB_L=1; FRAME_DONE at cycle 4. Re-enable with P=8/FB=10 clears CFG_ERR.
- Drop COUNTER_EN at BIT_COUNT=3, EDGE_COUNT=6: next cycle both counters are 0 and state is IDLE. Re-enable restarts at bit 0.
- Assert RST asynchronously mid-frame (between clock edges): outputs go to 0 immediately, with no strobe glitch after release while COUNTER_EN=0.

Source files
------------

// File: rtl/rx_edge_bit_counter_gen.sv
// rx_edge_bit_counter_gen: oversampling edge/bit counter for the UART receiver.
// Decodes three-point mid-bit sample strobes, bit/frame completion and config errors.
module rx_edge_bit_counter_gen #(
    parameter int PRESC_W      = 6,
    parameter int BIT_W        = 4,
    parameter int MIN_PRESCALE = 4,
    parameter bit AUTO_RESTART = 1'b0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               COUNTER_EN,
    input  logic [PRESC_W-1:0] PRESCALE,
    input  logic [BIT_W-1:0]   FRAME_BITS,
    output logic [PRESC_W-1:0] EDGE_COUNT,
    output logic [BIT_W-1:0]   BIT_COUNT,
    output logic [2:0]         SAMPLE_STRB,
    output logic               BIT_DONE,
    output logic               FRAME_DONE,
    output logic               CFG_ERR
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [PRESC_W-1:0] MIN_P   = PRESC_W'(MIN_PRESCALE);
    localparam logic [PRESC_W-1:0] P_ONE   = PRESC_W'(1);
    localparam logic [BIT_W-1:0]   FB_ONE  = BIT_W'(1);

    logic [1:0]         state, state_nxt;
    logic [PRESC_W-1:0] p_l, p_nxt;
    logic [BIT_W-1:0]   fb_l, fb_nxt;
    logic [PRESC_W-1:0] edge_nxt;
    logic [BIT_W-1:0]   bit_nxt;
    logic               err_nxt;

    logic               in_run;
    logic               last_bit;
    logic [PRESC_W-1:0] mid;
    logic               presc_bad;
    logic               fb_bad;

    // Output decodes depend only on registers, so they are glitch-free after reset release.
    assign in_run      = (state == ST_RUN);
    assign last_bit    = (BIT_COUNT == fb_l - FB_ONE);
    assign mid         = p_l >> 1;
    assign BIT_DONE    = in_run && (EDGE_COUNT == p_l);
    assign FRAME_DONE  = BIT_DONE && last_bit;

    assign SAMPLE_STRB[0] = in_run && (EDGE_COUNT == mid - P_ONE);
    assign SAMPLE_STRB[1] = in_run && (EDGE_COUNT == mid);
    assign SAMPLE_STRB[2] = in_run && (EDGE_COUNT == mid + P_ONE);

    assign presc_bad = (PRESCALE < MIN_P);
    assign fb_bad    = (FRAME_BITS == '0);

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt = state;
        edge_nxt  = EDGE_COUNT;
        bit_nxt   = BIT_COUNT;
        p_nxt     = p_l;
        fb_nxt    = fb_l;
        err_nxt   = CFG_ERR;

        if (!COUNTER_EN) begin
            state_nxt = ST_IDLE;
            edge_nxt  = '0;
            bit_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_RUN;
                    edge_nxt  = P_ONE;
                    bit_nxt   = '0;
                    p_nxt     = presc_bad ? MIN_P : PRESCALE;
                    fb_nxt    = fb_bad ? FB_ONE : FRAME_BITS;
                    err_nxt   = presc_bad || fb_bad;
                end
                ST_RUN: begin
                    if (BIT_DONE) begin
                        edge_nxt = P_ONE;
                        if (last_bit) begin
                            bit_nxt = '0;
                            if (!AUTO_RESTART) begin
                                state_nxt = ST_HOLD;
                                edge_nxt  = '0;
                            end
                        end else begin
                            bit_nxt = BIT_COUNT + FB_ONE;
                        end
                    end else begin
                        edge_nxt = EDGE_COUNT + P_ONE;
                    end
                end
                ST_HOLD: begin
                    edge_nxt = '0;
                    bit_nxt  = '0;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    edge_nxt  = '0;
                    bit_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            EDGE_COUNT <= '0;
            BIT_COUNT  <= '0;
            p_l        <= MIN_P;
            fb_l       <= FB_ONE;
            CFG_ERR    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            state      <= state_nxt;
            EDGE_COUNT <= edge_nxt;
            BIT_COUNT  <= bit_nxt;
            p_l        <= p_nxt;
            fb_l       <= fb_nxt;
            CFG_ERR    <= err_nxt;
        end
    end

endmodule

// File: tb/tb_rx_edge_bit_counter_gen.sv
// Bench for rx_edge_bit_counter_gen: vector table, directed corner sequences and
// randomized traffic against a cycles-since-enable reference model (both AUTO_RESTART values).
module tb_rx_edge_bit_counter_gen;

    localparam int PW = 6;
    localparam int BW = 4;

    typedef struct packed {
        logic [PW-1:0] edge_cnt;
        logic [BW-1:0] bit_cnt;
        logic [2:0]    strb;
        logic          bd;
        logic          fd;
        logic          err;
    } obs_t;

    typedef struct {
        bit            en;
        logic [PW-1:0] p;
        logic [BW-1:0] fb;
        logic [PW-1:0] e;
        logic [BW-1:0] b;
        logic [2:0]    s;
        bit            bd;
        bit            fd;
        bit            err;
    } vec_t;

    logic          CLK = 1'b0;
    logic          RST;
    logic          COUNTER_EN;
    logic [PW-1:0] PRESCALE;
    logic [BW-1:0] FRAME_BITS;

    logic [PW-1:0] e0, e1;
    logic [BW-1:0] b0, b1;
    logic [2:0]    s0, s1;
    logic          bd0, bd1, fd0, fd1, err0, err1;
    obs_t          obs0, obs1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model state: session active flag, cycles since the enable cycle, latched config.
    bit m_active;
    int m_t;
    int m_p;
    int m_fb;
    bit m_err;

    always #5 CLK = ~CLK;

    rx_edge_bit_counter_gen #(.PRESC_W(PW), .BIT_W(BW), .MIN_PRESCALE(4), .AUTO_RESTART(1'b0)) dut0 (
        .CLK(CLK), .RST(RST), .COUNTER_EN(COUNTER_EN), .PRESCALE(PRESCALE), .FRAME_BITS(FRAME_BITS),
        .EDGE_COUNT(e0), .BIT_COUNT(b0), .SAMPLE_STRB(s0), .BIT_DONE(bd0), .FRAME_DONE(fd0), .CFG_ERR(err0)
    );

    rx_edge_bit_counter_gen #(.PRESC_W(PW), .BIT_W(BW), .MIN_PRESCALE(4), .AUTO_RESTART(1'b1)) dut1 (
        .CLK(CLK), .RST(RST), .COUNTER_EN(COUNTER_EN), .PRESCALE(PRESCALE), .FRAME_BITS(FRAME_BITS),
        .EDGE_COUNT(e1), .BIT_COUNT(b1), .SAMPLE_STRB(s1), .BIT_DONE(bd1), .FRAME_DONE(fd1), .CFG_ERR(err1)
    );

    assign obs0 = {e0, b0, s0, bd0, fd0, err0};
    assign obs1 = {e1, b1, s1, bd1, fd1, err1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_active = 1'b0;
        m_t      = 0;
        m_err    = 1'b0;
    endfunction

    function automatic void model_clock(bit en, logic [PW-1:0] p, logic [BW-1:0] fb);
        if (!en) begin
            m_active = 1'b0;
            m_t      = 0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_t      = 1;
            m_p      = (int'(p) < 4) ? 4 : int'(p);
            m_fb     = (fb == 0) ? 1 : int'(fb);
            m_err    = (int'(p) < 4) || (fb == 0);
        end else begin
            m_t++;
        end
    endfunction

    // Expected outputs from position within the session: edge = ((t-1) mod P)+1, bit = ((t-1) div P) mod FB.
    function automatic obs_t model_out(bit ar);
        obs_t o;
        int   k, e, b;
        o     = '0;
        o.err = m_err;
        if (m_active && (ar || m_t <= m_p * m_fb)) begin
            k          = m_t - 1;
            e          = k % m_p + 1;
            b          = (k / m_p) % m_fb;
            o.edge_cnt = PW'(e);
            o.bit_cnt  = BW'(b);
            for (int i = 0; i < 3; i++) o.strb[i] = (e == m_p / 2 - 1 + i);
            o.bd = (e == m_p);
            o.fd = o.bd && (b == m_fb - 1);
        end
        return o;
    endfunction

    task automatic tick();
        model_clock(COUNTER_EN, PRESCALE, FRAME_BITS);
        @(posedge CLK);
        #1;
        cyc++;
        check("dut0 vs model", 32'(obs0), 32'(model_out(1'b0)));
        check("dut1 vs model", 32'(obs1), 32'(model_out(1'b1)));
    endtask

    task automatic apply_reset();
        RST = 1'b1;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("reset dut0 outputs", 32'(obs0), 32'd0);
        check("reset dut1 outputs", 32'(obs1), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        int   fd0_cnt, fd0_cyc, bd0_cnt, fd1_first, fd1_second, bd_p5, found;

        // en, PRESCALE, FRAME_BITS -> EDGE, BIT, STRB, BIT_DONE, FRAME_DONE, CFG_ERR (dut0)
        tbl[0] = '{1'b1, 6'd2,  4'd0,  6'd1, 4'd0, 3'b001, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 6'd9,  4'd3,  6'd2, 4'd0, 3'b010, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 6'd9,  4'd3,  6'd3, 4'd0, 3'b100, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 6'd9,  4'd3,  6'd4, 4'd0, 3'b000, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 6'd9,  4'd3,  6'd0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 6'd8,  4'd10, 6'd0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 6'd8,  4'd10, 6'd1, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 6'd8,  4'd10, 6'd2, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 6'd8,  4'd10, 6'd3, 4'd0, 3'b001, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 6'd8,  4'd10, 6'd0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0};

        COUNTER_EN = 1'b0;
        PRESCALE   = 6'd8;
        FRAME_BITS = 4'd10;
        apply_reset();
        tick();

        // Illegal config clamp, single-bit frame, HOLD, clear on a later legal latch.
        for (int i = 0; i < 10; i++) begin
            COUNTER_EN = tbl[i].en;
            PRESCALE   = tbl[i].p;
            FRAME_BITS = tbl[i].fb;
            tick();
            check($sformatf("tbl[%0d] edge", i), 32'(e0), 32'(tbl[i].e));
            check($sformatf("tbl[%0d] bit", i), 32'(b0), 32'(tbl[i].b));
            check($sformatf("tbl[%0d] strb", i), 32'(s0), 32'(tbl[i].s));
            check($sformatf("tbl[%0d] done", i), {30'd0, bd0, fd0}, {30'd0, tbl[i].bd, tbl[i].fd});
            check($sformatf("tbl[%0d] cfg_err", i), 32'(err0), 32'(tbl[i].err));
        end

        // P=8, FB=10 with enable held for two frames' worth of cycles.
        COUNTER_EN = 1'b1;
        PRESCALE   = 6'd8;
        FRAME_BITS = 4'd10;
        fd0_cnt = 0; fd0_cyc = -1; bd0_cnt = 0; fd1_first = -1; fd1_second = -1;
        for (int c = 1; c <= 165; c++) begin
            tick();
            if (fd0) begin fd0_cnt++; fd0_cyc = c; end
            if (bd0 && c <= 80) bd0_cnt++;
            if (fd1) begin
                if (fd1_first < 0) fd1_first = c;
                else if (fd1_second < 0) fd1_second = c;
            end
            if (c == 81) begin
                check("AR0 hold edge@81", 32'(e0), 32'd0);
                check("AR1 restart edge/bit@81", {e1, b1}, {6'd1, 4'd0});
            end
        end
        check("AR0 frame_done count", 32'(fd0_cnt), 32'd1);
        check("AR0 frame_done cycle", 32'(fd0_cyc), 32'd80);
        check("AR0 bit_done count", 32'(bd0_cnt), 32'd10);
        check("AR1 first frame_done", 32'(fd1_first), 32'd80);
        check("AR1 second frame_done", 32'(fd1_second), 32'd160);
        COUNTER_EN = 1'b0;
        tick();

        // Odd prescale, then a mid-frame PRESCALE change that must be ignored.
        COUNTER_EN = 1'b1;
        PRESCALE   = 6'd5;
        FRAME_BITS = 4'd4;
        bd_p5 = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1) check("P5 strobe edge1", 32'(s0), 32'b001);
            if (c == 7) PRESCALE = 6'd16;
            if (bd0) bd_p5++;
            if (c == 10) check("P5 bit_done@10", 32'(bd0), 32'd1);
        end
        check("P5 bit_done count", 32'(bd_p5), 32'd4);
        COUNTER_EN = 1'b0;
        tick();

        // Drop enable mid-frame at bit 3, edge 6.
        COUNTER_EN = 1'b1;
        PRESCALE   = 6'd8;
        FRAME_BITS = 4'd10;
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            tick();
            if (b0 == 4'd3 && e0 == 6'd6) found = 1;
        end
        check("reach bit3 edge6", 32'(found), 32'd1);
        COUNTER_EN = 1'b0;
        tick();
        check("drop counters", {e0, b0, e1, b1}, 32'd0);
        COUNTER_EN = 1'b1;
        tick();
        check("re-enable restart", {e0, b0}, {6'd1, 4'd0});

        // Asynchronous reset between clock edges, release with enable low.
        repeat (12) tick();
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        check("async reset dut0", 32'(obs0), 32'd0);
        check("async reset dut1", 32'(obs1), 32'd0);
        COUNTER_EN = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("post-reset strobes", {s0, s1}, 32'd0);
        end

        // Randomized traffic, including illegal configs and enable drops.
        for (int c = 0; c < 1500; c++) begin
            if (COUNTER_EN) COUNTER_EN = ($urandom_range(0, 29) != 0);
            else            COUNTER_EN = ($urandom_range(0, 2) == 0);
            PRESCALE   = ($urandom_range(0, 7) == 0) ? PW'($urandom_range(0, 63)) : PW'($urandom_range(0, 12));
            FRAME_BITS = ($urandom_range(0, 7) == 0) ? BW'($urandom_range(0, 15)) : BW'($urandom_range(0, 5));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
